// File: rtl/ram_bist.sv
// March-style BIST initiator for the Hack RAM: two write/read-compare passes
// (seeded address pattern, then its complement) reporting pass, error count and first failure.
module ram_bist #(
    parameter int REG_W = 16,
    parameter int REG_N = 64,
    localparam int ADDR_W = $clog2(REG_N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [REG_W-1:0]  seed,
    output logic [REG_W-1:0]  ram_in,
    output logic              ram_load,
    output logic [ADDR_W-1:0] ram_address,
    input  logic [REG_W-1:0]  ram_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W+1:0] err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              first_err_phase
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_W0   = 3'd1;
    localparam logic [2:0] S_R0   = 3'd2;
    localparam logic [2:0] S_W1   = 3'd3;
    localparam logic [2:0] S_R1   = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [REG_W-1:0]  seed_q, seed_d;
    logic [ADDR_W+1:0] err_q, err_d;
    logic [ADDR_W-1:0] fea_q, fea_d;
    logic              fep_q, fep_d;
    logic              pass_q, pass_d;

    logic [REG_W-1:0]  pattern;
    logic              last_addr;
    logic              mismatch;

    assign pattern   = seed_q ^ REG_W'(addr_q);
    assign last_addr = (addr_q == ADDR_W'(REG_N - 1));
    assign mismatch  = ((state_q == S_R0) && (ram_out != pattern)) ||
                       ((state_q == S_R1) && (ram_out != ~pattern));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        seed_d  = seed_q;
        err_d   = err_q;
        fea_d   = fea_q;
        fep_d   = fep_q;
        pass_d  = pass_q;

        // Error bookkeeping first so the final R1 compare is folded into pass.
        if (mismatch) begin
            if (err_q == '0) begin
                fea_d = addr_q;
                fep_d = (state_q == S_R1);
            end
            err_d = err_q + (ADDR_W+2)'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_W0;
                    seed_d  = seed;
                    addr_d  = '0;
                    err_d   = '0;
                    fea_d   = '0;
                    fep_d   = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            S_W0: begin
                addr_d = addr_q + ADDR_W'(1);
                if (last_addr) state_d = S_R0;
            end
            S_R0: begin
                addr_d = addr_q + ADDR_W'(1);
                if (last_addr) state_d = S_W1;
            end
            S_W1: begin
                addr_d = addr_q + ADDR_W'(1);
                if (last_addr) state_d = S_R1;
            end
            S_R1: begin
                addr_d = addr_q + ADDR_W'(1);
                if (last_addr) begin
                    state_d = S_DONE;
                    pass_d  = (err_d == '0);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            seed_q  <= '0;
            err_q   <= '0;
            fea_q   <= '0;
            fep_q   <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            seed_q  <= seed_d;
            err_q   <= err_d;
            fea_q   <= fea_d;
            fep_q   <= fep_d;
            pass_q  <= pass_d;
        end
    end

    // RAM-side outputs depend only on registered state, never on ram_out or start.
    assign ram_load        = (state_q == S_W0) || (state_q == S_W1);
    assign ram_address     = addr_q;
    assign ram_in          = (state_q == S_W0) ? pattern :
                             (state_q == S_W1) ? ~pattern : '0;
    assign busy            = (state_q == S_W0) || (state_q == S_R0) ||
                             (state_q == S_W1) || (state_q == S_R1);
    assign done            = (state_q == S_DONE);
    assign pass            = pass_q;
    assign err_count       = err_q;
    assign first_err_addr  = fea_q;
    assign first_err_phase = fep_q;

endmodule

// File: doc/ram_bist.md
# ram_bist

Built-in self-test initiator for the parameterised Hack `RAM` block. It drives the RAM's `in`/`load`/`address` port and reads the RAM's `out` port. On `start` it runs a two-pass write/read-compare sequence over every word: a seeded address pattern, then its bitwise complement. It reports pass/fail, the error count and the first failing address. It sits between the RAM and the test/boot controller, and owns the RAM port only while `busy`.

## Interface
- `REG_W`, default 16, RAM word width; must satisfy `REG_W >= ADDR_W`.
- `REG_N`, default 64, number of RAM words; must be a power of two.
- `ADDR_W`, default `$clog2(REG_N)`, address width; derived, not overridden.
- `clk`  in  1  single clock, rising-edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  level sampled in IDLE; begins a test run.
- `seed`  in  REG_W  pattern seed; sampled with `start`.
- `ram_in`  out  REG_W  write data to RAM `in`.
- `ram_load`  out  1  write enable to RAM `load`.
- `ram_address`  out  ADDR_W  to RAM `address`.
- `ram_out`  in  REG_W  RAM `out`; combinational read of `mem[ram_address]`.
- `busy`  out  1  high from the cycle after `start` is accepted until the run ends.
- `done`  out  1  one-cycle pulse when results are valid.
- `pass`  out  1  1 iff the last run had zero mismatches; held until the next accepted `start`.
- `err_count`  out  ADDR_W+2  mismatches in the last run; 0..2*REG_N, so no saturation is needed.
- `first_err_addr`  out  ADDR_W  address of the first mismatch; 0 if there was none.
- `first_err_phase`  out  1  0 = first mismatch was in R0, 1 = in R1.

## Operation
- Pattern: `P(a) = seed_q ^ zero_extend(a)`, where `seed_q` is the seed registered at `start`.
- State machine:
  - IDLE → W0 when `start`=1. Register `seed_q`, clear `addr`, `err_count` and the first-error fields, and set `pass` to 0.
  - W0: `ram_load`=1, `ram_address`=`addr`, `ram_in`=`P(addr)`. `addr` increments each cycle. After `addr`=REG_N-1, go to R0 with `addr`=0.
  - R0: `ram_load`=0. Each rising edge compares `ram_out` against `P(addr)` while `addr` is held that cycle, then increments `addr`. After `addr`=REG_N-1, go to W1.
  - W1: same as W0 with data `~P(addr)`.
  - R1: same as R0, expecting `~P(addr)`. After the last address, go to DONE.
  - DONE: `done`=1, `busy`=0, `pass` = (`err_count`==0). Go to IDLE on the next edge.
- Mismatch handling: any bit difference counts as one error per word per phase. `first_err_*` is captured only when `err_count`==0 before the increment.
- `ram_load` is asserted only in W0 and W1, and never in any other state.
- `start` is ignored in W0, R0, W1, R1 and DONE; no queuing.
- `addr` wraps naturally at REG_N-1 → 0 across phase changes.
- Async reset, any state:
  - Immediately: IDLE, `ram_load`=0, `ram_address`=0, `ram_in`=0.
  - Status outputs: `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_err_addr`=0, `first_err_phase`=0.
  - A run aborted by reset reports nothing.

## Timing
- Let E0 be the edge where `start` is accepted.
- W0 writes land on edges E1..E_N, for addresses 0..N-1.
- R0 compares occur on E_{N+1}..E_{2N}.
- W1 writes occur on E_{2N+1}..E_{3N}.
- R1 compares occur on E_{3N+1}..E_{4N}.
- DONE occupies the cycle after E_{4N}, so `done` is high exactly one cycle, 4·REG_N cycles after E0. For REG_N=64 that is 256 cycles.
- Back-to-back runs: `start` held high through DONE is accepted in IDLE on the following edge, giving a minimum gap of 1 idle cycle.
- The outputs driving the RAM port are decoded from registered state only; there is no combinational path from `ram_out` or `start` to `ram_load`.

## Test plan
- Reset then idle:
  - Stimulus: assert `rst_n`=0 mid-W0, at `addr`=17.
  - Required: `ram_load` drops with no further clock, all outputs take their reset values, and no RAM write occurs while reset is held.
- Clean run:
  - Stimulus: REG_N=64, `seed`=16'hA5A5, RAM model with no faults.
  - Required: `done` pulses 256 cycles after E0, `pass`=1, `err_count`=0.
  - Required: RAM word 5 reads 16'h5A5F (= ~(16'hA5A5 ^ 16'h0005)) after the run.
- Stuck-at-1 fault:
  - Stimulus: bit 0 of word 9 forced to 1, `seed`=16'h0000.
  - Required: R0 expects 16'h0009 and passes; R1 expects 16'hFFF6, mismatches.
  - Required: `err_count`=1, `first_err_addr`=9, `first_err_phase`=1, `pass`=0.
- Dead word:
  - Stimulus: word 63 always reads 0, `seed`=16'h0000.
  - Required: `err_count`=2 (R0 expects 16'h003F; R1 expects 16'hFFC0), `first_err_addr`=63, `first_err_phase`=0.
- Start ignored while busy:
  - Stimulus: pulse `start` at E0+40 with a different seed.
  - Required: the run completes with the original seed and `done` still pulses at E0+256.
  - Stimulus: then hold `start` high.
  - Required: the second run begins the edge after DONE, and `pass` reads 0 until that run's DONE.
